seq_serializer: RTL and testbench
=================================

Name: seq_serializer

Overview:
- Parallel-to-serial stage directly upstream of the bit-serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clk.
- Output bit x_out drives the detector's serial input x.
- Words accepted back-to-back produce a gapless bit stream, so patterns that span word boundaries are still detected.

Parameters:
- WIDTH, 8: data word width in bits. Legal range is 2 or more.
- IDLE_BIT, 1'b0: value driven on x_out whenever no word is being shifted.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset. The block is held in reset while reset==0.
- load_data  input  WIDTH  parallel word to serialize.
- load_valid  input  1  producer asserts when load_data is valid. Must hold load_data stable until accepted.
- load_ready  output  1  block can accept a word this cycle.
- x_out  output  1  serial bit (registered).
- x_valid  output  1  x_out carries a data or parity bit (registered).
- busy  output  1  state != IDLE.
- word_done  output  1  high during the cycle the final bit of a frame is on x_out.

Behaviour:
- Reset: synchronous, sampled on rising clk while reset==0.
  - Sets state=IDLE, shift register=0, bit counter=0.
  - Sets x_out=IDLE_BIT, x_valid=0, busy=0, word_done=0.
  - load_ready is forced to 0 while reset==0.
  - Reset mid-frame abandons the frame; the remaining bits are never emitted.
- State machine: IDLE, SHIFT, PARITY. PARITY exists only with the optional feature.
- Frame length FL = WIDTH, or WIDTH+1 with parity.
- Bit counter is $clog2(WIDTH+1) bits wide. It counts the bits of the current frame already presented.
- Accept occurs when load_valid && load_ready at a rising edge.
- Latency: on the accepting edge the shift register loads load_data, and x_out=load_data[WIDTH-1], x_valid=1 from that edge onward. That is one-cycle latency from accept to first bit.
- SHIFT: each edge shifts left by one. x_out takes the next-lower bit, and the counter increments.
  - The bit presented while counter==WIDTH-1 is load_data[0].
- last_cycle is the cycle the final bit of the frame is on x_out.
  - Without parity: SHIFT with counter==WIDTH-1.
  - With parity: the cycle in PARITY.
- load_ready = reset && (state==IDLE || last_cycle). This is combinational from registered state.
- word_done = last_cycle. It is a one-cycle pulse per frame.
- At the end of last_cycle:
  - If a word is accepted, the frame restarts immediately in SHIFT with the new MSB on x_out next cycle (no idle gap).
  - Otherwise go to IDLE with x_out=IDLE_BIT and x_valid=0.
- load_valid while load_ready==0 is ignored. The producer keeps holding its word, and no data is lost.
- Counter never exceeds FL-1. No wrap-around beyond the frame length.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - After load_data[0], one extra PARITY cycle drives x_out = XOR of the accepted word (even parity), with x_valid=1.
  - Parity is computed and stored at accept time.
  - FL=WIDTH+1, and load_ready/word_done move to the PARITY cycle.
- Undefined:
  - PARITY state and parity register are absent, FL=WIDTH, and SHIFT goes straight to IDLE or reload.

Decomposition:
- Shared package seq_pkg holds:
  - State enum type ser_state_t {IDLE, SHIFT, PARITY}.
  - Localparam helper for the counter width.
  - IDLE_BIT default constant shared with the detector bench.
- No sub-module is needed; the shift register, counter and FSM fit in one module.

Test Plan:
- Reset: hold reset=0 for 3 clocks with load_valid=1 → load_ready=0, x_valid=0, x_out=0, busy=0. Release → load_ready=1 the next cycle.
- Single word: load 8'hA5 → x_out 1,0,1,0,0,1,0,1 over 8 consecutive cycles starting one cycle after accept. x_valid high for exactly 8 cycles, word_done on the 8th, then x_out=0 and x_valid=0.
- Back-to-back: present 8'hA5 then 8'h5A with load_valid held → 16 contiguous x_valid cycles with no gap. Second word accepted on the first word's word_done cycle. Chained detector sees the stream 1010010101011010.
- Stall: assert load_valid with 8'hFF during cycle 3 of a frame → not accepted until the last_cycle. No bits are corrupted.
- Mid-frame reset: reset=0 after 4 bits of 8'hC3 → the next edge gives x_valid=0, x_out=0. After release, the earlier word is not resumed.
- Parity (SERIALIZER_PARITY_EN): 8'hA5 → 9 bits, final bit 0. 8'h07 → final bit 1. word_done is on the 9th bit.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the serializer and the sequence detector bench.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  // Line level presented on x_out when no frame is in flight.
  localparam logic IDLE_BIT_DEF = 1'b0;

  // Bit-counter width: must hold 0..WIDTH, since the parity beat sits at count WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding the bit-serial sequence detector.
// Words are shifted out MSB-first, one bit per clk. A word accepted on the
// final bit of the previous frame starts immediately, so the stream is gapless.
// Optional even-parity trailer bit: define SERIALIZER_PARITY_EN.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = cnt_w(WIDTH);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             last_cycle;
  logic             accept;
  logic             at_lsb;

`ifdef SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  assign at_lsb = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

`ifdef SERIALIZER_PARITY_EN
  assign last_cycle = (state_q == PARITY);
`else
  assign last_cycle = at_lsb;
`endif

  assign load_ready = reset && ((state_q == IDLE) || last_cycle);
  assign accept     = load_valid && load_ready;
  assign word_done  = last_cycle;
  assign busy       = (state_q != IDLE);
  assign x_out      = x_out_q;
  assign x_valid    = x_valid_q;

  // Next-state: accept takes priority, otherwise advance or retire the frame.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    x_out_d   = x_out_q;
    x_valid_d = x_valid_q;
`ifdef SERIALIZER_PARITY_EN
    par_d     = par_q;
`endif
    if (accept) begin
      state_d   = SHIFT;
      sr_d      = load_data;
      cnt_d     = '0;
      x_out_d   = load_data[WIDTH-1];
      x_valid_d = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      par_d     = ^load_data;
`endif
    end else if (last_cycle || state_q == IDLE) begin
      state_d   = IDLE;
      sr_d      = '0;
      cnt_d     = '0;
      x_out_d   = IDLE_BIT;
      x_valid_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    end else if (at_lsb) begin
      // Data exhausted: present the stored parity as the trailer beat.
      state_d = PARITY;
      cnt_d   = CW'(WIDTH);
      x_out_d = par_q;
`endif
    end else begin
      // Mid-frame shift: sr_q[WIDTH-1] is the bit on the wire now.
      sr_d    = sr_q << 1;
      x_out_d = sr_q[WIDTH-2];
      cnt_d   = cnt_q + CW'(1);
    end
  end

  // State register with synchronous active-low reset; reset abandons any frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      x_out_q   <= IDLE_BIT;
      x_valid_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
`ifdef SERIALIZER_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: a scoreboard queue holds the bits
// each accepted word must produce; every cycle the bench pops one and compares.
module tb_seq_serializer;
  import seq_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic b;
    logic last;
  } sb_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         load_ready, x_out, x_valid, busy, word_done;

  int  checks   = 0;
  int  failures = 0;
  sb_t sb[$];
  logic state_ready = 1'b1;  // model: DUT is in IDLE or on a frame's last bit
  logic acc_seen    = 1'b0;  // model: last edge accepted a word
  logic [15:0] stream;       // first 16 bits of the back-to-back test
  int   stream_n = 0;
  logic rec = 1'b0;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(W), .IDLE_BIT(IDLE_BIT_DEF)) dut (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .x_out(x_out), .x_valid(x_valid), .busy(busy),
    .word_done(word_done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: check ready, cross the edge, update the scoreboard, check outputs.
  task automatic tick();
    logic rst_edge, acc;
    sb_t  it;
    #1;
    chk("load_ready", load_ready, reset && state_ready);
    rst_edge = reset;
    acc      = reset && load_valid && state_ready;
    @(posedge clk);
    #1;
    acc_seen = acc;
    if (!rst_edge) sb.delete();
    else if (acc) begin
      for (int i = W - 1; i >= 0; i--) begin
        it.b = load_data[i];
`ifdef SERIALIZER_PARITY_EN
        it.last = 1'b0;
`else
        it.last = (i == 0);
`endif
        sb.push_back(it);
      end
`ifdef SERIALIZER_PARITY_EN
      it.b = ^load_data;
      it.last = 1'b1;
      sb.push_back(it);
`endif
    end
    if (sb.size() > 0) begin
      it = sb.pop_front();
      chk("x_valid", x_valid, 1'b1);
      chk("x_out", x_out, it.b);
      chk("word_done", word_done, it.last);
      chk("busy", busy, 1'b1);
      state_ready = it.last;
      if (rec && stream_n < 16) begin
        stream[15 - stream_n] = x_out;
        stream_n++;
      end
    end else begin
      chk("idle_x_valid", x_valid, 1'b0);
      chk("idle_x_out", x_out, IDLE_BIT_DEF);
      chk("idle_word_done", word_done, 1'b0);
      chk("idle_busy", busy, 1'b0);
      state_ready = 1'b1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Tick until the model sees an accept, bounded.
  task automatic wait_accept(input int limit);
    bit got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      got = acc_seen;
    end
    if (!got) begin
      checks++;
      failures++;
      $error("FAIL accept_timeout observed=none expected=accept within %0d", limit);
    end
  endtask

  initial begin
    // Reset held with a pending word: nothing may be accepted.
    reset = 1'b0; load_valid = 1'b1; load_data = 8'hA5;
    ticks(3);
    reset = 1'b1; load_valid = 1'b0;
    ticks(2);

    // Single word.
    load_valid = 1'b1; load_data = 8'hA5;
    wait_accept(4);
    load_valid = 1'b0;
    ticks(11);

    // Back-to-back words, valid held; second accepted on first's last bit.
    rec = 1'b1; stream_n = 0;
    load_valid = 1'b1; load_data = 8'hA5;
    wait_accept(4);
    load_data = 8'h5A;
    wait_accept(12);
    load_valid = 1'b0;
    ticks(11);
    rec = 1'b0;
`ifndef SERIALIZER_PARITY_EN
    chk("stream_len", stream_n == 16, 1'b1);
    checks++;
    assert (stream === 16'b1010010101011010) else begin
      failures++;
      $error("FAIL stream observed=%b expected=%b", stream, 16'b1010010101011010);
    end
`endif

    // Stall: new word offered mid-frame must wait for the last bit.
    load_valid = 1'b1; load_data = 8'h3C;
    wait_accept(4);
    load_valid = 1'b0;
    ticks(2);
    load_valid = 1'b1; load_data = 8'hFF;
    wait_accept(12);
    load_valid = 1'b0;
    ticks(11);

    // Mid-frame reset abandons the word.
    load_valid = 1'b1; load_data = 8'hC3;
    wait_accept(4);
    load_valid = 1'b0;
    ticks(3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ticks(10);

    // Parity-relevant words and a few random ones, streamed back-to-back.
    load_valid = 1'b1; load_data = 8'h07;
    wait_accept(4);
    for (int k = 0; k < 4; k++) begin
      load_data = W'($urandom_range(0, 255));
      wait_accept(12);
    end
    load_valid = 1'b0;
    ticks(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
